// File: rtl/phy_tx_multilane.sv
// Multi-lane transmit PHY: stripes DATA_W-bit words byte-wise across LANES serial lanes,
// MSB first, with a COM preamble after reset and IDL fill whenever no word is pending.
module phy_tx_multilane #(
  parameter int         DATA_W  = 32,
  parameter int         LANES   = 2,
  parameter int         COM_CNT = 4,
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [7:0] IDL_SYM = 8'h7C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANES-1:0]  serial_o,
  output logic              sym_start,
  output logic              data_active
);

  localparam int SET_W  = 8 * LANES;
  localparam int SLOTS  = DATA_W / SET_W;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CCNT_W = (COM_CNT > 1) ? $clog2(COM_CNT) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [CCNT_W-1:0] LAST_COM  = CCNT_W'(COM_CNT - 1);

  localparam logic [1:0] ST_COM  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  if ((LANES < 1) || (LANES > 8) || (COM_CNT < 1) || ((DATA_W % SET_W) != 0) || (DATA_W < SET_W))
  begin : g_bad_cfg
    $error("phy_tx_multilane: DATA_W must be a non-zero multiple of 8*LANES, LANES 1..8, COM_CNT >= 1");
  end

  // Lane i's current symbol lives in sr[8*i +: 8]; its MSB is on the wire.
  function automatic logic [SET_W-1:0] fill_sym(input logic [7:0] sym);
    logic [SET_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = sym;
    return r;
  endfunction

  // The most significant byte of a slot goes to lane 0.
  function automatic logic [SET_W-1:0] lane_map(input logic [SET_W-1:0] top);
    logic [SET_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = top[SET_W-1-8*i -: 8];
    return r;
  endfunction

  function automatic logic [SET_W-1:0] shift_lanes(input logic [SET_W-1:0] sr);
    logic [SET_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = {sr[8*i +: 7], 1'b0};
    return r;
  endfunction

  logic              run_q, run_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CCNT_W-1:0] com_cnt_q, com_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [SET_W-1:0]  sr_q, sr_d;
  logic              start_word;

  always_comb begin
    run_d       = run_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    com_cnt_d   = com_cnt_q;
    slot_d      = slot_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    word_d      = word_q;
    sr_d        = sr_q;
    start_word  = 1'b0;

    if (!run_q) begin
      // First edge out of reset opens the first COM symbol.
      run_d     = 1'b1;
      state_d   = ST_COM;
      bit_cnt_d = 3'd0;
      com_cnt_d = '0;
      slot_d    = '0;
      sr_d      = fill_sym(COM_SYM);
    end else if (bit_cnt_q != 3'd7) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      sr_d      = shift_lanes(sr_q);
    end else begin
      bit_cnt_d = 3'd0;
      case (state_q)
        ST_COM: begin
          if (com_cnt_q == LAST_COM) begin
            if (buf_valid_q) begin
              start_word = 1'b1;
            end else begin
              state_d = ST_IDLE;
              sr_d    = fill_sym(IDL_SYM);
            end
          end else begin
            com_cnt_d = com_cnt_q + CCNT_W'(1);
            sr_d      = fill_sym(COM_SYM);
          end
        end
        ST_DATA: begin
          if (slot_q == LAST_SLOT) begin
            if (buf_valid_q) begin
              start_word = 1'b1;
            end else begin
              state_d = ST_IDLE;
              sr_d    = fill_sym(IDL_SYM);
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
            sr_d   = lane_map(word_q[DATA_W-1 -: SET_W]);
            word_d = word_q << SET_W;
          end
        end
        default: begin
          if (buf_valid_q) begin
            start_word = 1'b1;
          end else begin
            state_d = ST_IDLE;
            sr_d    = fill_sym(IDL_SYM);
          end
        end
      endcase
    end

    // The buffer is released the moment its word goes on the wire.
    if (start_word) begin
      state_d     = ST_DATA;
      slot_d      = '0;
      sr_d        = lane_map(buf_data_q[DATA_W-1 -: SET_W]);
      word_d      = buf_data_q << SET_W;
      buf_valid_d = 1'b0;
    end

    if (in_valid && in_ready) begin
      buf_valid_d = 1'b1;
      buf_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q       <= 1'b0;
      state_q     <= ST_COM;
      bit_cnt_q   <= 3'd0;
      com_cnt_q   <= '0;
      slot_q      <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      com_cnt_q   <= com_cnt_d;
      slot_q      <= slot_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Datapath registers need no reset: every output is masked until run_q is set.
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    word_q     <= word_d;
    sr_q       <= sr_d;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) serial_o[i] = run_q & sr_q[8*i+7];
  end

  assign in_ready    = run_q & ~buf_valid_q;
  assign sym_start   = run_q & (bit_cnt_q == 3'd0);
  assign data_active = run_q & (state_q == ST_DATA);

endmodule
